disp_scan_driver: RTL and testbench

DISP_SCAN_DRIVER -- requirements
Module: disp_scan_driver

---
 rtl/scan_pkg.sv | 23 ++
 rtl/hex7seg_rom.sv | 11 +
 rtl/disp_scan_driver.sv | 120 ++++++++++++
 tb/tb_disp_scan_driver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scan driver:
// glyph table, idle codes and the per-slot BLANK/SHOW state encoding.
package scan_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] SCAN_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first so GLYPH_TBL[n] is glyph n.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex7seg_rom.sv
// Hex nibble to active-low 7-segment glyph lookup (pure combinational).
module hex7seg_rom
  import scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TBL[nib];

endmodule

// File: rtl/disp_scan_driver.sv
// Multiplexed 4-digit 7-segment scanner: prescaled digit slots with an
// anti-ghost blank window, frame-atomic value updates and leading-zero blanking.
module disp_scan_driver
  import scan_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] value,
  input  logic        upd,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic [3:0]  scan,
  output logic        frame_done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [1:0]    DIG_LAST   = 2'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    dig_q, dig_d;
  scan_state_e   state_q, state_d;
  logic [15:0]   pend_q, pend_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          first_q, first_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    scan_q, scan_d;
  logic          fd_q, fd_d;

  logic          slot_end, frame_end, boundary;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          lz_blank, show;

  assign slot_end  = (presc_q == PRESC_LAST);
  assign frame_end = slot_end && (dig_q == DIG_LAST);
  // The first cycle after reset acts as a frame boundary so an upd there lands at once.
  assign boundary  = frame_end || first_q;

  always_comb begin
    presc_d = slot_end ? '0 : presc_q + 1'b1;
    dig_d   = slot_end ? dig_q + 2'd1 : dig_q;
    first_d = 1'b0;
  end

  // Pending takes every upd; shadow only moves at a frame boundary.
  always_comb begin
    pend_d   = upd ? value : pend_q;
    shadow_d = boundary ? pend_d : shadow_q;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_BLANK;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (presc_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end)              state_d = ST_BLANK;
      default:                             state_d = ST_BLANK;
    endcase
  end

  // FSM: outputs
  assign nib = shadow_q[{dig_q, 2'b00} +: 4];

  hex7seg_rom u_rom (
    .nib   (nib),
    .glyph (glyph)
  );

  always_comb begin
    lz_blank = 1'b0;
    case (dig_q)
      2'd3: lz_blank = (shadow_q[15:12] == 4'h0);
      2'd2: lz_blank = (shadow_q[15:8]  == 8'h00);
      2'd1: lz_blank = (shadow_q[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
    show   = (state_q == ST_SHOW) && !(lz_en && lz_blank);
    seg_d  = show ? glyph : SEG_OFF;
    scan_d = show ? ~(4'b0001 << dig_q) : SCAN_OFF;
    fd_d   = frame_end;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc_q  <= '0;
      dig_q    <= '0;
      pend_q   <= '0;
      shadow_q <= '0;
      first_q  <= 1'b1;
      seg_q    <= SEG_OFF;
      scan_q   <= SCAN_OFF;
      fd_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      dig_q    <= dig_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      first_q  <= first_d;
      seg_q    <= seg_d;
      scan_q   <= scan_d;
      fd_q     <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign scan       = scan_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Bench for disp_scan_driver (TICK_DIV=8, BLANK_CYC=2): table vectors, corner
// sequences and random traffic, all checked against a cycle-count reference model.
module tb_disp_scan_driver;

  localparam int TD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] value = '0;
  logic        upd = 1'b0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  scan;
  logic        frame_done;

  disp_scan_driver #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk(clk), .clr(clr), .value(value), .upd(upd), .lz_en(lz_en),
    .seg(seg), .scan(scan), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference state: cycles since reset release, pending and shadow values
  int          n = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_sh = '0;
  logic        lz_r = 1'b0;

  function automatic logic [6:0] ref_glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare against the model.
  task automatic step(input logic u, input logic [15:0] v);
    int c, d;
    logic shw;
    logic [3:0] es;
    logic [6:0] eg;
    upd = u; value = v; lz_en = lz_r;
    @(posedge clk);
    @(negedge clk);
    c = n % TD;
    d = (n / TD) % 4;
    shw = (c >= BC) && !(lz_r && d != 0 && (m_sh >> (4 * d)) == 16'h0);
    es = shw ? ~(4'b0001 << d) : 4'b1111;
    eg = shw ? ref_glyph(4'((m_sh >> (4 * d)) & 16'hF)) : 7'b1111111;
    chk("model", {20'h0, frame_done, scan, seg}, {20'h0, (c == TD - 1 && d == 3), es, eg});
    if (u) m_pend = v;
    if (n == 0 || (c == TD - 1 && d == 3)) m_sh = m_pend;
    n++;
    upd = 1'b0;
  endtask

  // Advance until the cycle just completed is slot cycle c of digit d.
  task automatic adv_to(input int c, input int d);
    int k = 0;
    do begin
      step(1'b0, 16'h0);
      k++;
    end while (!(((n - 1) % TD) == c && (((n - 1) / TD) % 4) == d) && k < 40);
    if (k >= 40) chk("adv_timeout", 32'(k), 32'(0));
  endtask

  task automatic chk_digit(input string nm, input int d, input logic [6:0] eg);
    logic [3:0] es;
    adv_to(4, d);
    es = (eg == 7'b1111111) ? 4'b1111 : ~(4'b0001 << d);
    chk(nm, {21'h0, scan, seg}, {21'h0, es, eg});
  endtask

  task automatic release_reset();
    @(negedge clk);
    clr = 1'b1;
    n = 0; m_pend = '0; m_sh = '0;
  endtask

  typedef struct {
    logic [15:0] val;
    logic        lz;
    logic [6:0]  eseg [4];
  } vec_t;

  vec_t vec [8];

  initial begin
    int pulses, last_fd, gap;
    logic bad;

    vec[0] = '{16'h1234, 1'b0, '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}};
    vec[1] = '{16'h0070, 1'b1, '{7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111}};
    vec[2] = '{16'h0000, 1'b1, '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111}};
    vec[3] = '{16'h0000, 1'b0, '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vec[4] = '{16'h0F00, 1'b1, '{7'b1000000, 7'b1000000, 7'b0001110, 7'b1111111}};
    vec[5] = '{16'h89AB, 1'b0, '{7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000}};
    vec[6] = '{16'hCDE5, 1'b1, '{7'b0010010, 7'b0000110, 7'b0100001, 7'b1000110}};
    vec[7] = '{16'h0006, 1'b1, '{7'b0000010, 7'b1111111, 7'b1111111, 7'b1111111}};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {20'h0, frame_done, scan, seg}, {20'h0, 1'b0, 4'b1111, 7'b1111111});
    release_reset();

    // table vectors: load mid-frame, check each SHOW slot of the next frame
    foreach (vec[i]) begin
      lz_r = vec[i].lz;
      adv_to(3, 1);
      step(1'b1, vec[i].val);
      adv_to(TD - 1, 3);
      for (int d = 0; d < 4; d++) chk_digit($sformatf("vec%0d_d%0d", i, d), d, vec[i].eseg[d]);
    end

    // tearing: two updates inside one frame, only the last may ever show
    lz_r = 1'b0;
    adv_to(3, 1);
    step(1'b1, 16'hABCD);
    adv_to(2, 2);
    step(1'b1, 16'h0001);
    adv_to(TD - 1, 3);
    bad = 1'b0;
    for (int k = 0; k < 4 * TD; k++) begin
      step(1'b0, 16'h0);
      if (seg == 7'b0001000 || seg == 7'b0000011 || seg == 7'b1000110 || seg == 7'b0100001)
        bad = 1'b1;
    end
    chk("tear_no_abcd", {31'h0, bad}, 32'h0);
    chk_digit("tear_d0", 0, 7'b1111001);
    chk_digit("tear_d3", 3, 7'b1000000);

    // upd on the wrap cycle itself
    adv_to(TD - 2, 3);
    step(1'b1, 16'hFFFF);
    for (int d = 0; d < 4; d++) chk_digit($sformatf("wrap_d%0d", d), d, 7'b0001110);

    // frame_done spacing
    pulses = 0; last_fd = -1; gap = 4 * TD;
    for (int k = 0; k < 8 * TD; k++) begin
      step(1'b0, 16'h0);
      if (frame_done) begin
        if (last_fd >= 0) gap = n - last_fd;
        last_fd = n;
        pulses++;
      end
    end
    chk("fd_count", 32'(pulses), 32'd2);
    chk("fd_period", 32'(gap), 32'(4 * TD));

    // async reset in SHOW of digit2, then upd on the first cycle after release
    adv_to(4, 2);
    #2 clr = 1'b0;
    #1 chk("async_clr", {20'h0, frame_done, scan, seg}, {20'h0, 1'b0, 4'b1111, 7'b1111111});
    @(negedge clk);
    chk("clr_hold", {21'h0, scan, seg}, {21'h0, 4'b1111, 7'b1111111});
    release_reset();
    lz_r = 1'b0;
    step(1'b1, 16'h00A5);
    chk("post_clr_c0", {21'h0, scan, seg}, {21'h0, 4'b1111, 7'b1111111});
    adv_to(BC, 0);
    chk("post_clr_show", {21'h0, scan, seg}, {21'h0, 4'b1110, 7'b0010010});

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [15:0] rv;
      rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      if ($urandom_range(0, 31) == 0) lz_r = 1'($urandom);
      step($urandom_range(0, 7) == 0, rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
